// File: rtl/dff_pkg.sv
// Shared constants and parameter sanity helper for the dff_pipeline family.
package dff_pkg;

    localparam int RETIME_OFF        = 32'sd0;
    localparam int RETIME_ON         = 32'sd1;
    localparam int DFF_DEFAULT_DEPTH = 32'sd1;

    function automatic bit params_legal(input int width, input int size1,
                                        input int size2, input int depth);
        return (width >= 32'sd1) && (size1 >= 32'sd1) &&
               (size2 >= 32'sd1) && (depth >= 32'sd0);
    endfunction

endpackage

// File: rtl/dff.sv
// Scalar wrapper around dff_pipeline.
module dff
    import dff_pkg::*;
#(
    parameter int WIDTH         = 32'sd1,
    parameter int PIPE_DEPTH    = DFF_DEFAULT_DEPTH,
    parameter int RETIME_STATUS = RETIME_OFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    dff_pipeline #(
        .WIDTH        (WIDTH),
        .ARRAY_SIZE1  (32'sd1),
        .ARRAY_SIZE2  (32'sd1),
        .PIPE_DEPTH   (PIPE_DEPTH),
        .RETIME_STATUS(RETIME_STATUS)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .in   (in),
        .out  (out)
    );

endmodule

// File: rtl/dff2.sv
// 1-D wrapper: ARRAY_SIZE maps onto the inner dimension of dff_pipeline.
module dff2
    import dff_pkg::*;
#(
    parameter int WIDTH         = 32'sd1,
    parameter int ARRAY_SIZE    = 32'sd1,
    parameter int PIPE_DEPTH    = DFF_DEFAULT_DEPTH,
    parameter int RETIME_STATUS = RETIME_OFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [ARRAY_SIZE-1:0][WIDTH-1:0] in,
    output logic [ARRAY_SIZE-1:0][WIDTH-1:0] out
);

    dff_pipeline #(
        .WIDTH        (WIDTH),
        .ARRAY_SIZE1  (32'sd1),
        .ARRAY_SIZE2  (ARRAY_SIZE),
        .PIPE_DEPTH   (PIPE_DEPTH),
        .RETIME_STATUS(RETIME_STATUS)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .in   (in),
        .out  (out)
    );

endmodule

// File: rtl/dff3.sv
// Full 2-D wrapper around dff_pipeline.
module dff3
    import dff_pkg::*;
#(
    parameter int WIDTH         = 32'sd1,
    parameter int ARRAY_SIZE1   = 32'sd1,
    parameter int ARRAY_SIZE2   = 32'sd1,
    parameter int PIPE_DEPTH    = DFF_DEFAULT_DEPTH,
    parameter int RETIME_STATUS = RETIME_OFF
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           en,
    input  logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] in,
    output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] out
);

    dff_pipeline #(
        .WIDTH        (WIDTH),
        .ARRAY_SIZE1  (ARRAY_SIZE1),
        .ARRAY_SIZE2  (ARRAY_SIZE2),
        .PIPE_DEPTH   (PIPE_DEPTH),
        .RETIME_STATUS(RETIME_STATUS)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .in   (in),
        .out  (out)
    );

endmodule

// File: rtl/dff_pipeline_check.sv
// Parameter and enable sanity checks, compiled only with DFF_PIPELINE_CHECK_EN.
`ifdef DFF_PIPELINE_CHECK_EN
module dff_pipeline_check
    import dff_pkg::*;
#(
    parameter int WIDTH       = 32'sd1,
    parameter int ARRAY_SIZE1 = 32'sd1,
    parameter int ARRAY_SIZE2 = 32'sd1,
    parameter int PIPE_DEPTH  = DFF_DEFAULT_DEPTH
) (
    input logic clk,
    input logic reset,
    input logic en
);

    if (!params_legal(WIDTH, ARRAY_SIZE1, ARRAY_SIZE2, PIPE_DEPTH)) begin : g_bad_params
        $error("dff_pipeline: illegal WIDTH/ARRAY_SIZE/PIPE_DEPTH");
    end

    // Enable must be known whenever the pipe is out of reset
    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(en)) else $error("dff_pipeline: en is X/Z at clock edge");
        end
    end

endmodule
`endif

// File: rtl/dff_stage.sv
// One array-wide pipeline register; RETIME_STATUS selects a synchronous
// active-low clear or a reset-free register that synthesis may retime.
module dff_stage
    import dff_pkg::*;
#(
    parameter int WIDTH         = 32'sd1,
    parameter int ARRAY_SIZE1   = 32'sd1,
    parameter int ARRAY_SIZE2   = 32'sd1,
    parameter int RETIME_STATUS = RETIME_OFF
) (
    input  logic                                           clk_i,
    input  logic                                           reset_ni,
    input  logic                                           en_i,
    input  logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] d_i,
    output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] q_o
);

    logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] data_d;
    logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] data_q;

    // Next state: load on enable, otherwise hold
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end else begin
            data_d = data_q;
        end
    end

    if (RETIME_STATUS == RETIME_OFF) begin : g_reset
        // Clear wins over enable
        always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end
    end else begin : g_retime
        logic unused_reset_s;
        assign unused_reset_s = reset_ni;

        // No reset fan-out so the register can move freely
        always_ff @(posedge clk_i) begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/dff_pipeline.sv
// Enable-gated PIPE_DEPTH-stage delay line for scalar/1-D/2-D data.
// Optional checks enabled by defining DFF_PIPELINE_CHECK_EN.
module dff_pipeline
    import dff_pkg::*;
#(
    parameter int WIDTH         = 32'sd1,
    parameter int ARRAY_SIZE1   = 32'sd1,
    parameter int ARRAY_SIZE2   = 32'sd1,
    parameter int PIPE_DEPTH    = DFF_DEFAULT_DEPTH,
    parameter int RETIME_STATUS = RETIME_OFF
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           en,
    input  logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] in,
    output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] out
);

    typedef logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] arr_t;

    // chain_s[k] feeds stage k; chain_s[PIPE_DEPTH] is the pipe output
    arr_t chain_s [PIPE_DEPTH+1];

    assign chain_s[0] = in;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        dff_stage #(
            .WIDTH        (WIDTH),
            .ARRAY_SIZE1  (ARRAY_SIZE1),
            .ARRAY_SIZE2  (ARRAY_SIZE2),
            .RETIME_STATUS(RETIME_STATUS)
        ) u_stage (
            .clk_i   (clk),
            .reset_ni(reset),
            .en_i    (en),
            .d_i     (chain_s[k]),
            .q_o     (chain_s[k+1])
        );
    end

    if (PIPE_DEPTH == 0) begin : g_passthru
        logic unused_ctrl_s;
        assign unused_ctrl_s = ^{clk, reset, en};
    end

    assign out = chain_s[PIPE_DEPTH];

`ifdef DFF_PIPELINE_CHECK_EN
    dff_pipeline_check #(
        .WIDTH      (WIDTH),
        .ARRAY_SIZE1(ARRAY_SIZE1),
        .ARRAY_SIZE2(ARRAY_SIZE2),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_check (
        .clk  (clk),
        .reset(reset),
        .en   (en)
    );
`endif

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed scoreboard bench for dff_pipeline: latency, stall, reset, retime,
// zero depth and a scalar pulse through the dff wrapper.
module tb_dff_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] sb_q   [$];
    logic [255:0] pipe_q [$];

    // A: 24-bit 3x3, depth 3
    logic rst_a = 1'b1, en_a = 1'b0;
    logic [2:0][2:0][23:0] in_a = '0, out_a;
    // B: 32-bit, depth 2 (stall)
    logic rst_b = 1'b1, en_b = 1'b0;
    logic [31:0] in_b = 32'd0, out_b;
    // C: 32-bit, depth 3 (reset mid-stream)
    logic rst_c = 1'b1, en_c = 1'b0;
    logic [31:0] in_c = 32'd0, out_c;
    // D: 32-bit, depth 1, retime
    logic rst_d = 1'b1, en_d = 1'b0;
    logic [31:0] in_d = 32'd0, out_d;
    // E: 32-bit, depth 0
    logic rst_e = 1'b1, en_e = 1'b0;
    logic [31:0] in_e = 32'd0, out_e;
    // F: scalar dff, depth 2
    logic rst_f = 1'b1, en_f = 1'b0;
    logic in_f = 1'b0, out_f;

    dff_pipeline #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3), .RETIME_STATUS(0))
        u_a (.clk(clk), .reset(rst_a), .en(en_a), .in(in_a), .out(out_a));
    dff_pipeline #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(2), .RETIME_STATUS(0))
        u_b (.clk(clk), .reset(rst_b), .en(en_b), .in(in_b), .out(out_b));
    dff_pipeline #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(3), .RETIME_STATUS(0))
        u_c (.clk(clk), .reset(rst_c), .en(en_c), .in(in_c), .out(out_c));
    dff_pipeline #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(1), .RETIME_STATUS(1))
        u_d (.clk(clk), .reset(rst_d), .en(en_d), .in(in_d), .out(out_d));
    dff_pipeline #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(0), .RETIME_STATUS(0))
        u_e (.clk(clk), .reset(rst_e), .en(en_e), .in(in_e), .out(out_e));
    dff #(.WIDTH(1), .PIPE_DEPTH(2), .RETIME_STATUS(0))
        u_f (.clk(clk), .reset(rst_f), .en(en_f), .in(in_f), .out(out_f));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pipe contents; pipe_q[0] is the oldest stage (the output).
    task automatic sb_reset(input int depth);
        pipe_q.delete();
        for (int i = 0; i < depth; i++) pipe_q.push_back('0);
    endtask

    task automatic sb_step(input logic en_v, input logic rst_v, input logic [255:0] din,
                           input bit retime);
        if (!rst_v && !retime) begin
            foreach (pipe_q[i]) pipe_q[i] = '0;
        end else if (en_v) begin
            pipe_q.push_back(din);
            void'(pipe_q.pop_front());
        end
        sb_q.push_back(pipe_q[0]);
    endtask

    task automatic sb_check(input string tag, input logic [255:0] obs);
        logic [255:0] e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %0h, expected <scoreboard empty>", tag, obs);
        end else begin
            e = sb_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_a(input logic r, input logic e, input logic [2:0][2:0][23:0] d);
        rst_a = r; en_a = e; in_a = d;
        sb_step(e, r, 256'(d), 1'b0);
        tick();
        sb_check("latency", 256'(out_a));
    endtask

    task automatic cyc_b(input logic r, input logic e, input logic [31:0] d);
        rst_b = r; en_b = e; in_b = d;
        sb_step(e, r, 256'(d), 1'b0);
        tick();
        sb_check("stall", 256'(out_b));
    endtask

    task automatic cyc_c(input logic r, input logic e, input logic [31:0] d);
        rst_c = r; en_c = e; in_c = d;
        sb_step(e, r, 256'(d), 1'b0);
        tick();
        sb_check("reset", 256'(out_c));
    endtask

    task automatic cyc_d(input logic r, input logic e, input logic [31:0] d);
        rst_d = r; en_d = e; in_d = d;
        sb_step(e, r, 256'(d), 1'b1);
        tick();
        sb_check("retime", 256'(out_d));
    endtask

    task automatic cyc_f(input logic r, input logic e, input logic d);
        rst_f = r; en_f = e; in_f = d;
        sb_step(e, r, 256'(d), 1'b0);
        tick();
        sb_check("scalar", 256'(out_f));
    endtask

    initial begin : stim
        logic [2:0][2:0][23:0] pa;
        logic [31:0] v;

        tick();

        // Latency through 3x3 array, single element pulse
        sb_reset(3);
        cyc_a(1'b0, 1'b1, '0);
        chk("a_reset_state", 256'(out_a), 256'd0);
        pa = '0;
        pa[2][1] = 24'h00ABCD;
        cyc_a(1'b1, 1'b1, pa);
        cyc_a(1'b1, 1'b1, '0);
        cyc_a(1'b1, 1'b1, '0);
        chk("a_elem_2_1", 256'(out_a[2][1]), 256'(24'h00ABCD));
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b1, '0);

        // Stall: stream 1,2,3... with a 4-cycle en gap
        sb_reset(2);
        cyc_b(1'b0, 1'b1, 32'd0);
        v = 32'd1;
        for (int i = 0; i < 6; i++) begin cyc_b(1'b1, 1'b1, v); v = v + 32'd1; end
        for (int i = 0; i < 4; i++) cyc_b(1'b1, 1'b0, v);
        for (int i = 0; i < 6; i++) begin cyc_b(1'b1, 1'b1, v); v = v + 32'd1; end
        for (int i = 0; i < 2; i++) cyc_b(1'b1, 1'b1, 32'd0);

        // Mid-stream reset with en high
        sb_reset(3);
        cyc_c(1'b0, 1'b1, 32'd0);
        cyc_c(1'b1, 1'b1, 32'd5);
        cyc_c(1'b1, 1'b1, 32'd6);
        cyc_c(1'b1, 1'b1, 32'd7);
        chk("c_filled", 256'(out_c), 256'd5);
        cyc_c(1'b0, 1'b1, 32'd8);
        cyc_c(1'b1, 1'b1, 32'd9);
        cyc_c(1'b1, 1'b1, 32'd10);
        cyc_c(1'b1, 1'b1, 32'd11);
        chk("c_after_reset", 256'(out_c), 256'd9);
        cyc_c(1'b1, 1'b1, 32'd12);

        // Retime: reset ignored
        sb_reset(1);
        cyc_d(1'b1, 1'b1, 32'd9);
        cyc_d(1'b0, 1'b0, 32'd20);
        chk("d_hold_in_reset", 256'(out_d), 256'd9);
        cyc_d(1'b0, 1'b1, 32'd10);
        cyc_d(1'b1, 1'b1, 32'd11);

        // Zero depth: combinational, en/reset irrelevant
        for (int i = 0; i < 100; i++) begin
            in_e  = $urandom();
            en_e  = 1'($urandom_range(1, 0));
            rst_e = 1'($urandom_range(1, 0));
            sb_q.push_back(256'(in_e));
            #2;
            sb_check("zero_depth", 256'(out_e));
        end

        // Scalar valid pulse through dff, depth 2
        tick();
        sb_reset(2);
        cyc_f(1'b0, 1'b1, 1'b0);
        cyc_f(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc_f(1'b1, 1'b1, 1'b0);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_leftover: observed %0d entries, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
